// File: rtl/cond_unit.sv
// Condition/flag unit: holds NZCV, evaluates ARM condition codes and gates PC/reg/mem write strobes.
// Latency: strobes and the flag update appear one cycle after alu_valid is sampled, at least 2 cycles after acceptance.
// Backpressure: instr_ready drops while an accepted instruction executes; instr_valid is ignored until IDLE.
module cond_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] cond,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       alu_valid,
    input  logic [3:0] alu_flags,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic       cond_undef,
    output logic [3:0] flags_q
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Handshake events derived from the current state.
    logic accept;
    logic finish;

    // Combinational condition result against the flags as they are now.
    logic cond_pass;

    // Unpacked view of the architectural flags.
    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    // Controls captured at acceptance and used when the ALU reports done.
    logic [1:0] flag_w_q;
    logic       pcs_q;
    logic       reg_w_q;
    logic       mem_w_q;
    logic       no_write_q;

    assign n_flag = flags_q[3];
    assign z_flag = flags_q[2];
    assign c_flag = flags_q[1];
    assign v_flag = flags_q[0];

    // State register: reset always returns to IDLE, aborting any execution.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE waits for an instruction, EXEC waits for the ALU.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (alu_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs: ready only in IDLE; completion only recognised in EXEC.
    always_comb begin
        instr_ready = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
            end
            EXEC: begin
                finish = alu_valid;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    assign accept = instr_ready & instr_valid;

    // ARM condition table; 4'hF is undefined and never executes.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = z_flag;
            4'h1: cond_pass = ~z_flag;
            4'h2: cond_pass = c_flag;
            4'h3: cond_pass = ~c_flag;
            4'h4: cond_pass = n_flag;
            4'h5: cond_pass = ~n_flag;
            4'h6: cond_pass = v_flag;
            4'h7: cond_pass = ~v_flag;
            4'h8: cond_pass = c_flag & ~z_flag;
            4'h9: cond_pass = ~c_flag | z_flag;
            4'hA: cond_pass = (n_flag == v_flag);
            4'hB: cond_pass = (n_flag != v_flag);
            4'hC: cond_pass = ~z_flag & (n_flag == v_flag);
            4'hD: cond_pass = z_flag | (n_flag != v_flag);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Capture the instruction's write/flag controls at acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_w_q   <= 2'b00;
            pcs_q      <= 1'b0;
            reg_w_q    <= 1'b0;
            mem_w_q    <= 1'b0;
            no_write_q <= 1'b0;
        end else if (accept) begin
            flag_w_q   <= flag_w;
            pcs_q      <= pcs;
            reg_w_q    <= reg_w;
            mem_w_q    <= mem_w;
            no_write_q <= no_write;
        end
    end

    // Condition result holds until the next acceptance; undefined-cond flag pulses for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cond_ex    <= 1'b0;
            cond_undef <= 1'b0;
        end else begin
            cond_undef <= accept & (cond == 4'hF);
            if (accept) begin
                cond_ex <= cond_pass;
            end
        end
    end

    // Flag update at completion of an executing instruction; ALU flags stored verbatim.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= FLAG_RST;
        end else if (finish && cond_ex) begin
            if (flag_w_q[1]) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (flag_w_q[0]) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    // Write strobes: single-cycle registered pulses following completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_src    <= 1'b0;
            reg_write <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            pc_src    <= finish & pcs_q & cond_ex;
            reg_write <= finish & reg_w_q & cond_ex & ~no_write_q;
            mem_write <= finish & mem_w_q & cond_ex;
        end
    end

endmodule
